// File: rtl/or1200_vlx_pkg.sv
// Shared VLX definitions (load and store units): buffer geometry and fetch FSM states.
package or1200_vlx_pkg;

  localparam int VLX_BUF_W   = 32;
  localparam int VLX_MAX_GET = 16;
  localparam int VLX_CNT_W   = $clog2(VLX_BUF_W + 1);

  typedef enum logic [0:0] {
    F_IDLE = 1'b0,
    F_REQ  = 1'b1
  } vlx_fetch_t;

endpackage

// File: rtl/or1200_vlx_bitbuf.sv
// MSB-first bit buffer: shift-out of n bits and byte append in the same cycle,
// with the append landing after the shift so ordering is preserved.
module or1200_vlx_bitbuf #(
  parameter int BUF_W = 32,
  parameter int CNT_W = $clog2(BUF_W + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             consume_i,
  input  logic [CNT_W-1:0] n_i,
  input  logic             append_i,
  input  logic [7:0]       byte_i,
  output logic [BUF_W-1:0] buf_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [BUF_W-1:0] buf_q, buf_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_after;

  always_comb begin
    shifted   = consume_i ? (buf_q << n_i) : buf_q;
    cnt_after = consume_i ? (cnt_q - n_i) : cnt_q;
    buf_d     = shifted;
    cnt_d     = cnt_after;
    if (append_i) begin
      // Bits below the valid region are always zero, so OR-ing places the byte.
      buf_d = shifted | ({{(BUF_W-8){1'b0}}, byte_i} << (CNT_W'(BUF_W - 8) - cnt_after));
      cnt_d = cnt_after + CNT_W'(8);
    end
    if (flush_i) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign buf_o = buf_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/or1200_vlx_lu.sv
// VLX load unit: byte fetch FSM, address counter and get-bits handshake over the bit buffer.
// Optional JPEG 0xFF00 unstuffing when OR1200_VLX_UNSTUFF_EN is defined.
module or1200_vlx_lu
  import or1200_vlx_pkg::*;
#(
  parameter int BUF_W   = VLX_BUF_W,
  parameter int MAX_GET = VLX_MAX_GET,
  parameter int CNT_W   = $clog2(BUF_W + 1),
  parameter int NB_W    = $clog2(MAX_GET + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               set_init_addr_i,
  input  logic [31:0]        dat_i,
  output logic               load_byte_o,
  output logic [31:0]        vlx_addr_o,
  input  logic               ack_i,
  input  logic [7:0]         mem_dat_i,
  input  logic               get_bits_i,
  input  logic [NB_W-1:0]    nbits_i,
  output logic [MAX_GET-1:0] bits_o,
  output logic               bits_valid_o,
  output logic               stall_o,
  output logic [CNT_W-1:0]   bit_cnt_o
);

  vlx_fetch_t         state_q, state_d;
  logic [31:0]        addr_q;
  logic               stall_q, valid_q;
  logic [CNT_W-1:0]   pend_n_q, n_in, n_eff;
  logic [MAX_GET-1:0] bits_q;
  logic [BUF_W-1:0]   buf_w, field;
  logic [CNT_W-1:0]   cnt_w;
  logic               req, active, consume, ack_ok, drop, append;

  assign n_in = (nbits_i == '0 || nbits_i > NB_W'(MAX_GET)) ? CNT_W'(MAX_GET) : CNT_W'(nbits_i);

  // A new request is only accepted when nothing is pending and no result is showing.
  assign req     = get_bits_i && !stall_q && !valid_q;
  assign active  = req || stall_q;
  assign n_eff   = req ? n_in : pend_n_q;
  assign consume = active && (cnt_w >= n_eff) && !set_init_addr_i;
  assign field   = buf_w >> (CNT_W'(BUF_W) - n_eff);
  assign ack_ok  = (state_q == F_REQ) && ack_i && !set_init_addr_i;
  assign append  = ack_ok && !drop;

`ifdef OR1200_VLX_UNSTUFF_EN
  logic ff_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                ff_q <= 1'b0;
    else if (set_init_addr_i) ff_q <= 1'b0;
    else if (ack_ok)          ff_q <= (mem_dat_i == 8'hFF);
  end
  assign drop = ff_q && (mem_dat_i == 8'h00);
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (set_init_addr_i)                                    state_d = F_IDLE;
    else if (state_q == F_IDLE && cnt_w <= CNT_W'(BUF_W - 8)) state_d = F_REQ;
    else if (state_q == F_REQ && ack_i)                     state_d = F_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= F_IDLE;
      addr_q   <= '0;
      stall_q  <= 1'b0;
      valid_q  <= 1'b0;
      pend_n_q <= '0;
      bits_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= consume;
      if (set_init_addr_i) addr_q <= dat_i;
      else if (ack_ok)     addr_q <= addr_q + 32'd1;
      stall_q <= active && !consume && !set_init_addr_i;
      if (req) pend_n_q <= n_in;
      if (consume) bits_q <= field[MAX_GET-1:0];
    end
  end

  or1200_vlx_bitbuf #(.BUF_W(BUF_W), .CNT_W(CNT_W)) u_bitbuf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (set_init_addr_i),
    .consume_i (consume),
    .n_i       (n_eff),
    .append_i  (append),
    .byte_i    (mem_dat_i),
    .buf_o     (buf_w),
    .cnt_o     (cnt_w)
  );

  assign load_byte_o  = (state_q == F_REQ);
  assign vlx_addr_o   = addr_q;
  assign bits_o       = bits_q;
  assign bits_valid_o = valid_q;
  assign stall_o      = stall_q;
  assign bit_cnt_o    = cnt_w;

endmodule

// File: tb/tb_or1200_vlx_lu.sv
// Directed bench for the VLX load unit; expected values computed by hand.
module tb_or1200_vlx_lu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        set_init_addr_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic        load_byte_o;
  logic [31:0] vlx_addr_o;
  logic        ack_i = 1'b0;
  logic [7:0]  mem_dat_i = '0;
  logic        get_bits_i = 1'b0;
  logic [4:0]  nbits_i = '0;
  logic [15:0] bits_o;
  logic        bits_valid_o;
  logic        stall_o;
  logic [5:0]  bit_cnt_o;

  int passed = 0;
  int total  = 0;

  or1200_vlx_lu dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .set_init_addr_i (set_init_addr_i),
    .dat_i           (dat_i),
    .load_byte_o     (load_byte_o),
    .vlx_addr_o      (vlx_addr_o),
    .ack_i           (ack_i),
    .mem_dat_i       (mem_dat_i),
    .get_bits_i      (get_bits_i),
    .nbits_i         (nbits_i),
    .bits_o          (bits_o),
    .bits_valid_o    (bits_valid_o),
    .stall_o         (stall_o),
    .bit_cnt_o       (bit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (load_byte_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(tag, {31'd0, load_byte_o}, 32'd1);
  endtask

  task automatic ack_byte(input logic [7:0] b);
    wait_req("req_wait");
    ack_i = 1'b1;
    mem_dat_i = b;
    step();
    ack_i = 1'b0;
    mem_dat_i = '0;
  endtask

  task automatic do_get(input logic [4:0] n);
    get_bits_i = 1'b1;
    nbits_i = n;
    step();
    get_bits_i = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    set_init_addr_i = 1'b1;
    dat_i = a;
    step();
    set_init_addr_i = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_addr", vlx_addr_o, 32'd0);
    check("rst_load", {31'd0, load_byte_o}, 32'd0);
    check("rst_bits", {16'd0, bits_o}, 32'd0);
    check("rst_valid", {31'd0, bits_valid_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_cnt", {26'd0, bit_cnt_o}, 32'd0);
    rst_i = 1'b0;
    step();

    // 1: fill the buffer from 0x100
    set_addr(32'h100);
    check("t1_addr_init", vlx_addr_o, 32'h100);
    ack_byte(8'hA5);
    check("t1_addr1", vlx_addr_o, 32'h101);
    check("t1_cnt1", {26'd0, bit_cnt_o}, 32'd8);
    ack_byte(8'h3C);
    check("t1_addr2", vlx_addr_o, 32'h102);
    ack_byte(8'h12);
    ack_byte(8'h34);
    check("t1_cnt_full", {26'd0, bit_cnt_o}, 32'd32);
    step();
    step();
    step();
    check("t1_no_req", {31'd0, load_byte_o}, 32'd0);
    check("t1_addr4", vlx_addr_o, 32'h104);

    // 2: get 4 then get 12
    do_get(5'd4);
    check("t2_valid4", {31'd0, bits_valid_o}, 32'd1);
    check("t2_bits4", {16'd0, bits_o}, 32'h000A);
    check("t2_cnt28", {26'd0, bit_cnt_o}, 32'd28);
    step();
    check("t2_valid_pulse", {31'd0, bits_valid_o}, 32'd0);
    do_get(5'd12);
    check("t2_bits12", {16'd0, bits_o}, 32'h053C);
    check("t2_cnt16", {26'd0, bit_cnt_o}, 32'd16);

    // 3: get from an empty buffer stalls until data arrives
    set_addr(32'h300);
    check("t3_cnt0", {26'd0, bit_cnt_o}, 32'd0);
    do_get(5'd5);
    check("t3_stall", {31'd0, stall_o}, 32'd1);
    check("t3_novalid", {31'd0, bits_valid_o}, 32'd0);
    ack_byte(8'hF8);
    check("t3_stall_ack", {31'd0, stall_o}, 32'd1);
    check("t3_cnt8", {26'd0, bit_cnt_o}, 32'd8);
    step();
    check("t3_valid", {31'd0, bits_valid_o}, 32'd1);
    check("t3_bits", {16'd0, bits_o}, 32'h001F);
    check("t3_stall_clr", {31'd0, stall_o}, 32'd0);
    check("t3_cnt3", {26'd0, bit_cnt_o}, 32'd3);

    // 4: ack and get 8 in the same cycle at bit_cnt 24
    set_addr(32'h400);
    ack_byte(8'h11);
    ack_byte(8'h22);
    ack_byte(8'h33);
    check("t4_cnt24a", {26'd0, bit_cnt_o}, 32'd24);
    wait_req("t4_req");
    ack_i = 1'b1;
    mem_dat_i = 8'h44;
    get_bits_i = 1'b1;
    nbits_i = 5'd8;
    step();
    ack_i = 1'b0;
    get_bits_i = 1'b0;
    check("t4_bits", {16'd0, bits_o}, 32'h0011);
    check("t4_cnt24b", {26'd0, bit_cnt_o}, 32'd24);
    step();
    do_get(5'd16);
    check("t4_bits16", {16'd0, bits_o}, 32'h2233);
    step();
    do_get(5'd8);
    check("t4_bits8", {16'd0, bits_o}, 32'h0044);
    check("t4_cnt0", {26'd0, bit_cnt_o}, 32'd0);

    // 5: set_init_addr during F_REQ with a same-cycle ack and a stalled get
    step();
    do_get(5'd16);
    check("t5_stall", {31'd0, stall_o}, 32'd1);
    wait_req("t5_req");
    set_init_addr_i = 1'b1;
    dat_i = 32'h2000;
    ack_i = 1'b1;
    mem_dat_i = 8'h77;
    step();
    set_init_addr_i = 1'b0;
    ack_i = 1'b0;
    check("t5_addr", vlx_addr_o, 32'h2000);
    check("t5_cnt", {26'd0, bit_cnt_o}, 32'd0);
    check("t5_stall_clr", {31'd0, stall_o}, 32'd0);
    check("t5_idle", {31'd0, load_byte_o}, 32'd0);
    step();
    check("t5_no_valid", {31'd0, bits_valid_o}, 32'd0);
    ack_byte(8'h80);
    do_get(5'd1);
    check("t5_dropped", {16'd0, bits_o}, 32'h0001);
    check("t5_addr1", vlx_addr_o, 32'h2001);

    // 6: FF 00 D9 with and without unstuffing
    set_addr(32'h3000);
    ack_byte(8'hFF);
    ack_byte(8'h00);
    ack_byte(8'hD9);
    check("t6_addr", vlx_addr_o, 32'h3003);
`ifdef OR1200_VLX_UNSTUFF_EN
    check("t6_cnt", {26'd0, bit_cnt_o}, 32'd16);
    do_get(5'd16);
    check("t6_bits", {16'd0, bits_o}, 32'hFFD9);
`else
    check("t6_cnt", {26'd0, bit_cnt_o}, 32'd24);
    do_get(5'd16);
    check("t6_bits", {16'd0, bits_o}, 32'hFF00);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
